// File: rtl/window_buffer_stream.sv
// Sliding-window line buffer: raster beats in, ROWS x WIN patches out at any
// column offset through a single registered, back-pressured output stage.
module window_buffer_stream #(
  parameter int PIX_W = 16,
  parameter int ROWS  = 16,
  parameter int COLS  = 80,
  parameter int WIN   = 16,
  parameter int BEAT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BEAT*PIX_W-1:0]         in_data,
  input  logic                          win_req,
  output logic                          win_req_ready,
  input  logic [$clog2(COLS)-1:0]       win_col,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [ROWS*WIN*PIX_W-1:0]     win_data,
  output logic                          win_full,
  output logic                          win_err,
  output logic [$clog2(ROWS+1)-1:0]     fill_rows,
  output logic                          row_done
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW    = $clog2(ROWS + 1);
  localparam int NOFF  = COLS - WIN + 1;
  localparam int NSLOT = COLS / BEAT;

  generate
    if (COLS % BEAT != 0) begin : g_bad_beat
      $error("window_buffer_stream: COLS must be a multiple of BEAT");
    end
    if (WIN > COLS) begin : g_bad_win
      $error("window_buffer_stream: WIN must not exceed COLS");
    end
  endgenerate

  typedef enum logic [1:0] {S_CLEAR, S_FILL, S_STREAM} state_t;

  state_t                         state_q, state_d;
  logic [COLS-1:0][PIX_W-1:0]     store_q [ROWS];
  logic [COLS-1:0][PIX_W-1:0]     store_d [ROWS];
  logic [RW-1:0]                  wr_row_q, wr_row_d;
  logic [CW-1:0]                  wr_col_q, wr_col_d;
  logic [FW-1:0]                  fill_rows_q, fill_rows_d;
  logic [RW-1:0]                  clr_cnt_q, clr_cnt_d;
  logic                           row_done_q, row_done_d;
  logic                           win_valid_q, win_valid_d;
  logic [ROWS*WIN*PIX_W-1:0]      win_data_q, win_data_d;
  logic                           win_full_q, win_full_d;
  logic                           win_err_q, win_err_d;

  logic [PIX_W-1:0]               beat_pix [BEAT];
  logic [ROWS*WIN*PIX_W-1:0]      patch_sel;
  logic                           beat_acc, req_acc, col_ok, row_end;

  // Pixel k of a beat sits k slots down from the MSB end of in_data.
  genvar gi;
  generate
    for (gi = 0; gi < BEAT; gi++) begin : g_pix
      assign beat_pix[gi] = in_data[(BEAT-gi)*PIX_W-1 -: PIX_W];
    end
  endgenerate

  assign in_ready      = (state_q != S_CLEAR);
  assign win_req_ready = ~win_valid_q | win_ready;
  assign beat_acc      = in_valid & in_ready;
  assign req_acc       = win_req & win_req_ready;
  assign col_ok        = (win_col <= CW'(COLS - WIN));
  assign row_end       = (wr_col_q == CW'(COLS - BEAT));

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    fill_rows_d = fill_rows_q;
    clr_cnt_d   = clr_cnt_q;
    row_done_d  = 1'b0;
    if (frame_start) begin
      // A beat arriving with frame_start is dropped; the store is untouched.
      state_d     = S_CLEAR;
      clr_cnt_d   = '0;
      wr_row_d    = '0;
      wr_col_d    = '0;
      fill_rows_d = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          for (int i = 0; i < ROWS; i++) begin
            if (clr_cnt_q == RW'(i)) store_d[i] = '0;
          end
          if (clr_cnt_q == RW'(ROWS - 1)) begin
            state_d     = S_FILL;
            wr_row_d    = '0;
            wr_col_d    = '0;
            fill_rows_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + RW'(1);
          end
        end
        S_FILL: begin
          if (beat_acc) begin
            for (int i = 0; i < ROWS; i++)
              for (int b = 0; b < NSLOT; b++)
                for (int k = 0; k < BEAT; k++)
                  if (wr_row_q == RW'(i) && wr_col_q == CW'(b*BEAT))
                    store_d[i][b*BEAT+k] = beat_pix[k];
            if (row_end) begin
              wr_col_d    = '0;
              row_done_d  = 1'b1;
              fill_rows_d = fill_rows_q + FW'(1);
              if (fill_rows_q == FW'(ROWS - 1)) begin
                state_d  = S_STREAM;
                wr_row_d = '0;
              end else begin
                wr_row_d = wr_row_q + RW'(1);
              end
            end else begin
              wr_col_d = wr_col_q + CW'(BEAT);
            end
          end
        end
        S_STREAM: begin
          if (beat_acc) begin
            // Scroll on the first beat of a row, then write into the bottom row.
            if (wr_col_q == '0) begin
              for (int i = 0; i < ROWS-1; i++) store_d[i] = store_q[i+1];
              store_d[ROWS-1] = '0;
            end
            for (int b = 0; b < NSLOT; b++)
              for (int k = 0; k < BEAT; k++)
                if (wr_col_q == CW'(b*BEAT))
                  store_d[ROWS-1][b*BEAT+k] = beat_pix[k];
            if (row_end) begin
              wr_col_d   = '0;
              row_done_d = 1'b1;
            end else begin
              wr_col_d = wr_col_q + CW'(BEAT);
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    patch_sel = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < WIN; c++)
        for (int o = 0; o < NOFF; o++)
          if (win_col == CW'(o))
            patch_sel[(r*WIN+c)*PIX_W +: PIX_W] = store_q[r][o+c];
  end

  always_comb begin
    win_valid_d = win_valid_q & ~win_ready;
    win_data_d  = win_data_q;
    win_full_d  = win_full_q;
    win_err_d   = 1'b0;
    if (req_acc) begin
      if (col_ok) begin
        win_valid_d = 1'b1;
        win_data_d  = patch_sel;
        win_full_d  = (fill_rows_q == FW'(ROWS));
      end else begin
        win_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      for (int i = 0; i < ROWS; i++) store_q[i] <= '0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      fill_rows_q <= '0;
      clr_cnt_q   <= '0;
      row_done_q  <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_full_q  <= 1'b0;
      win_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      fill_rows_q <= fill_rows_d;
      clr_cnt_q   <= clr_cnt_d;
      row_done_q  <= row_done_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_full_q  <= win_full_d;
      win_err_q   <= win_err_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_full  = win_full_q;
  assign win_err   = win_err_q;
  assign fill_rows = fill_rows_q;
  assign row_done  = row_done_q;

endmodule
